// File: rtl/slave_resp_mux.sv
// slave_resp_mux: return path from the bus slaves to the master.
// The decoder's one-hot select is captured in the address phase and steers
// HRDATA/HREADY/HRESP during the data phase. The block also acts as the
// default slave: unmapped or illegal decodes and slave timeouts are answered
// with a two-cycle ERROR response.
module slave_resp_mux #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              sel_s0,
   input  logic              sel_s1,
   input  logic              sel_s2,
   input  logic [1:0]        HTRANS,
   input  logic [DATA_W-1:0] HRDATA_S0,
   input  logic [DATA_W-1:0] HRDATA_S1,
   input  logic [DATA_W-1:0] HRDATA_S2,
   input  logic              HREADYOUT_S0,
   input  logic              HREADYOUT_S1,
   input  logic              HREADYOUT_S2,
   input  logic              HRESP_S0,
   input  logic              HRESP_S1,
   input  logic              HRESP_S2,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADY,
   output logic              HRESP,
   output logic              timeout_flag
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SLV0 = 3'd1,
      ST_SLV1 = 3'd2,
      ST_SLV2 = 3'd3,
      ST_ERR1 = 3'd4,
      ST_ERR2 = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  wcnt_r;
   logic [CNT_W-1:0]  wcnt_nxt_s;
   logic              flag_r;
   logic              flag_set_s;
   logic              is_slv_s;
   logic [DATA_W-1:0] hrdata_s;
   logic              hready_s;
   logic              hresp_s;
   logic              htrans_unused_s;

   // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
   assign htrans_unused_s = HTRANS[0];

   // Map an address phase onto the data-phase state it opens.
   function automatic state_t decode_addr(input logic active, input logic [2:0] sel);
      state_t st;
      if (!active) begin
         st = ST_IDLE;
      end else begin
         case (sel)
            3'b001:  st = ST_SLV0;
            3'b010:  st = ST_SLV1;
            3'b100:  st = ST_SLV2;
            default: st = ST_ERR1;
         endcase
      end
      return st;
   endfunction

   assign is_slv_s = (state_r == ST_SLV0) || (state_r == ST_SLV1) || (state_r == ST_SLV2);

   // State, wait counter and sticky timeout flag registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r <= ST_IDLE;
         wcnt_r  <= {CNT_W{1'b0}};
         flag_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         wcnt_r  <= wcnt_nxt_s;
         flag_r  <= flag_r | flag_set_s;
      end
   end

   // Next state: sample the address phase when HREADY is high, otherwise
   // count slave wait cycles and force an error once the budget is spent.
   always_comb begin
      state_nxt_s = state_r;
      wcnt_nxt_s  = {CNT_W{1'b0}};
      flag_set_s  = 1'b0;
      if (hready_s) begin
         state_nxt_s = decode_addr(HTRANS[1], {sel_s2, sel_s1, sel_s0});
      end else if (is_slv_s) begin
         if (wcnt_r == WCNT_MAX) begin
            state_nxt_s = ST_ERR1;
            flag_set_s  = 1'b1;
         end else begin
            wcnt_nxt_s = wcnt_r + CNT_W'(1'b1);
         end
      end else if (state_r == ST_ERR1) begin
         state_nxt_s = ST_ERR2;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Output decode: route the selected slave or produce the default-slave response.
   always_comb begin
      hrdata_s = {DATA_W{1'b0}};
      hready_s = 1'b1;
      hresp_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            hrdata_s = {DATA_W{1'b0}};
            hready_s = 1'b1;
            hresp_s  = 1'b0;
         end
         ST_SLV0: begin
            hrdata_s = HRDATA_S0;
            hready_s = HREADYOUT_S0;
            hresp_s  = HRESP_S0;
         end
         ST_SLV1: begin
            hrdata_s = HRDATA_S1;
            hready_s = HREADYOUT_S1;
            hresp_s  = HRESP_S1;
         end
         ST_SLV2: begin
            hrdata_s = HRDATA_S2;
            hready_s = HREADYOUT_S2;
            hresp_s  = HRESP_S2;
         end
         ST_ERR1: begin
            hrdata_s = {DATA_W{1'b0}};
            hready_s = 1'b0;
            hresp_s  = 1'b1;
         end
         ST_ERR2: begin
            hrdata_s = {DATA_W{1'b0}};
            hready_s = 1'b1;
            hresp_s  = 1'b1;
         end
         default: begin
            hrdata_s = {DATA_W{1'b0}};
            hready_s = 1'b1;
            hresp_s  = 1'b0;
         end
      endcase
   end

   assign HRDATA       = hrdata_s;
   assign HREADY       = hready_s;
   assign HRESP        = hresp_s;
   assign timeout_flag = flag_r;

endmodule
